// File: rtl/simon_dec_key_prep.sv
// Simon decryption key pre-expansion: runs the forward key schedule and presents the
// last NKW round keys in reverse order. Define SIMON_KEYPREP_2STEP_EN for two steps per cycle.
module simon_dec_key_prep #(
    parameter int WW  = 16,
    parameter int NKW = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               key_valid_i,
    output logic               key_ready_o,
    input  logic [NKW*WW-1:0]  key_i,
    output logic               rkey_valid_o,
    input  logic               rkey_ready_i,
    output logic [NKW*WW-1:0]  rkey_o,
    output logic [5:0]         zidx_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef logic [NKW-1:0][WW-1:0] kstate_t;

    // Total schedule length T; zero marks an illegal (WW,NKW) pair.
    function automatic int sched_rounds(input int w, input int m);
        int r;
        r = 0;
        if      (w == 16 && m == 4) r = 32;
        else if (w == 24 && m == 3) r = 36;
        else if (w == 24 && m == 4) r = 36;
        else if (w == 32 && m == 3) r = 42;
        else if (w == 32 && m == 4) r = 44;
        else if (w == 48 && m == 2) r = 52;
        else if (w == 48 && m == 3) r = 54;
        else if (w == 64 && m == 2) r = 68;
        else if (w == 64 && m == 3) r = 69;
        else if (w == 64 && m == 4) r = 72;
        return r;
    endfunction

    // Sequences as published, z_0 in the leftmost (most significant) digit.
    function automatic logic [61:0] z_published(input int w, input int m);
        logic [61:0] z;
        z = 62'b11111010001001010110000111001101111101000100101011000011100110;
        if (w == 24 && m == 4)
            z = 62'b10001110111110010011000010110101000111011111001001100001011010;
        else if ((w == 32 && m == 3) || (w == 48 && m == 2) || (w == 64 && m == 2))
            z = 62'b10101111011100000011010010011000101000010001111110010110110011;
        else if ((w == 32 && m == 4) || (w == 48 && m == 3) || (w == 64 && m == 3))
            z = 62'b11011011101011000110010111100000010010001010011100110100001111;
        else if (w == 64 && m == 4)
            z = 62'b11010001111001101011011000100000010111000011001010010011101111;
        return z;
    endfunction

    function automatic logic [61:0] reverse62(input logic [61:0] p);
        logic [61:0] r;
        for (int i = 0; i < 62; i++) r[i] = p[61-i];
        return r;
    endfunction

    localparam int              T_ROUNDS  = sched_rounds(WW, NKW);
    localparam bit              LEGAL     = (T_ROUNDS != 0);
    localparam int              NSTEP     = LEGAL ? T_ROUNDS - NKW : 2;
    localparam logic [61:0]     ZSEQ      = reverse62(z_published(WW, NKW));
    localparam logic [WW-1:0]   C_CONST   = {{(WW-2){1'b1}}, 2'b00};
    localparam logic [5:0]      ZIDX_LAST = 6'((NSTEP - 1) % 62);
    localparam logic [6:0]      LAST_CNT  = 7'(NSTEP - 1);

    if (!LEGAL) begin : g_illegal_params
        $error("simon_dec_key_prep: unsupported (WW,NKW) pair");
    end

    function automatic logic [WW-1:0] ror1(input logic [WW-1:0] x);
        return {x[0], x[WW-1:1]};
    endfunction

    function automatic logic [WW-1:0] ror3(input logic [WW-1:0] x);
        return {x[2:0], x[WW-1:3]};
    endfunction

    // One forward schedule step: words shift down, the new top word is derived.
    function automatic kstate_t sched_step(input kstate_t s, input logic zb);
        kstate_t         r;
        logic [WW-1:0]   t;
        for (int i = 0; i < NKW - 1; i++) r[i] = s[i+1];
        t = ror3(s[NKW-1]);
        if (NKW == 4) t = t ^ s[1];
        r[NKW-1] = s[0] ^ t ^ ror1(t) ^ C_CONST ^ {{(WW-1){1'b0}}, zb};
        return r;
    endfunction

    state_t              state;
    kstate_t             ks;
    logic [6:0]          step_cnt;
    logic [5:0]          zcnt;

    kstate_t             ks_one;
    kstate_t             ks_run;
    logic [5:0]          zcnt_p1;
    logic [5:0]          zcnt_run;
    logic [6:0]          cnt_run;
    logic                run_last;
    logic [NKW*WW-1:0]   rkey_next;

`ifdef SIMON_KEYPREP_2STEP_EN
    localparam logic [6:0] LAST2_CNT = 7'(NSTEP - 2);
    kstate_t             ks_two;
    logic [5:0]          zcnt_p2;
`endif

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        zcnt_p1 = (zcnt == 6'd61) ? 6'd0 : zcnt + 6'd1;
        ks_one  = sched_step(ks, ZSEQ[zcnt]);
`ifdef SIMON_KEYPREP_2STEP_EN
        zcnt_p2  = (zcnt_p1 == 6'd61) ? 6'd0 : zcnt_p1 + 6'd1;
        ks_two   = sched_step(ks_one, ZSEQ[zcnt_p1]);
        // Odd NSTEP leaves a single step for the final cycle.
        ks_run   = (step_cnt == LAST_CNT) ? ks_one : ks_two;
        zcnt_run = zcnt_p2;
        cnt_run  = step_cnt + 7'd2;
        run_last = (step_cnt == LAST_CNT) || (step_cnt == LAST2_CNT);
`else
        ks_run   = ks_one;
        zcnt_run = zcnt_p1;
        cnt_run  = step_cnt + 7'd1;
        run_last = (step_cnt == LAST_CNT);
`endif
        rkey_next = '0;
        for (int i = 0; i < NKW; i++) rkey_next[i*WW +: WW] = ks_run[NKW-1-i];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the key state is a handful of flops, not a RAM, so it is reset with the rest.
            state        <= S_IDLE;
            ks           <= '0;
            step_cnt     <= '0;
            zcnt         <= '0;
            key_ready_o  <= 1'b1;
            rkey_valid_o <= 1'b0;
            rkey_o       <= '0;
            zidx_o       <= '0;
            busy_o       <= 1'b0;
        end else if (flush_i) begin
            state        <= S_IDLE;
            step_cnt     <= '0;
            zcnt         <= '0;
            key_ready_o  <= 1'b1;
            rkey_valid_o <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (key_valid_i && key_ready_o) begin
                        ks          <= kstate_t'(key_i);
                        step_cnt    <= '0;
                        zcnt        <= '0;
                        state       <= S_RUN;
                        key_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                    end
                end
                S_RUN: begin
                    ks       <= ks_run;
                    step_cnt <= cnt_run;
                    zcnt     <= zcnt_run;
                    if (run_last) begin
                        state        <= S_DONE;
                        busy_o       <= 1'b0;
                        rkey_valid_o <= 1'b1;
                        rkey_o       <= rkey_next;
                        zidx_o       <= ZIDX_LAST;
                    end
                end
                S_DONE: begin
                    if (rkey_ready_i) begin
                        state        <= S_IDLE;
                        rkey_valid_o <= 1'b0;
                        key_ready_o  <= 1'b1;
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    key_ready_o  <= 1'b1;
                    rkey_valid_o <= 1'b0;
                    busy_o       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_dec_key_prep.sv
// Randomized bench for simon_dec_key_prep: three configurations (16/4, 64/4, 24/3)
// checked against a full-schedule reference model built from the published z strings.
module tb_simon_dec_key_prep;

    localparam int NI = 3;
    localparam int CW [NI] = '{16, 64, 24};
    localparam int CM [NI] = '{4, 4, 3};
    localparam int CT [NI] = '{32, 72, 36};
    localparam int CZ [NI] = '{0, 4, 0};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          key_valid [NI];
    logic          key_ready [NI];
    logic          rkey_valid [NI];
    logic          rkey_ready [NI];
    logic          busy [NI];
    logic [255:0]  key_in [NI];
    logic [5:0]    zidx [NI];
    logic [63:0]   rkey0;
    logic [255:0]  rkey1;
    logic [71:0]   rkey2;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    simon_dec_key_prep #(.WW(16), .NKW(4)) u_dut16 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .key_valid_i(key_valid[0]), .key_ready_o(key_ready[0]), .key_i(key_in[0][63:0]),
        .rkey_valid_o(rkey_valid[0]), .rkey_ready_i(rkey_ready[0]), .rkey_o(rkey0),
        .zidx_o(zidx[0]), .busy_o(busy[0])
    );

    simon_dec_key_prep #(.WW(64), .NKW(4)) u_dut64 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .key_valid_i(key_valid[1]), .key_ready_o(key_ready[1]), .key_i(key_in[1]),
        .rkey_valid_o(rkey_valid[1]), .rkey_ready_i(rkey_ready[1]), .rkey_o(rkey1),
        .zidx_o(zidx[1]), .busy_o(busy[1])
    );

    simon_dec_key_prep #(.WW(24), .NKW(3)) u_dut24 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .key_valid_i(key_valid[2]), .key_ready_o(key_ready[2]), .key_i(key_in[2][71:0]),
        .rkey_valid_o(rkey_valid[2]), .rkey_ready_i(rkey_ready[2]), .rkey_o(rkey2),
        .zidx_o(zidx[2]), .busy_o(busy[2])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] get_rkey(input int sel);
        case (sel)
            0:       return 256'(rkey0);
            1:       return rkey1;
            default: return 256'(rkey2);
        endcase
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
        return r;
    endfunction

    // z_j is character j of the published sequence.
    function automatic logic zbit(input int zs, input int j);
        string s;
        case (zs)
            0:       s = "11111010001001010110000111001101111101000100101011000011100110";
            1:       s = "10001110111110010011000010110101000111011111001001100001011010";
            2:       s = "10101111011100000011010010011000101000010001111110010110110011";
            3:       s = "11011011101011000110010111100000010010001010011100110100001111";
            default: s = "11010001111001101011011000100000010111000011001010010011101111";
        endcase
        return s.getc(j) == "1";
    endfunction

    function automatic logic [63:0] ror_w(input logic [63:0] x, input int r, input int w,
                                          input logic [63:0] mask);
        return ((x >> r) | (x << (w - r))) & mask;
    endfunction

    // Reference: expand the whole schedule k_0..k_{T-1}, then take the last NKW words reversed.
    task automatic model(input int sel, input logic [255:0] key, output logic [255:0] rk,
                         output logic [255:0] zi, output int lat);
        int           w, m, t, ns;
        logic [63:0]  mask, c, tmp;
        logic [63:0]  k [$];
        logic [255:0] kk;
        w = CW[sel]; m = CM[sel]; t = CT[sel]; ns = t - m;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        c = mask & ~64'd3;
        for (int i = 0; i < m; i++) begin
            kk = key >> (i * w);
            k.push_back(kk[63:0] & mask);
        end
        for (int i = m; i < t; i++) begin
            tmp = ror_w(k[i-1], 3, w, mask);
            if (m == 4) tmp = tmp ^ k[i-3];
            k.push_back(k[i-m] ^ tmp ^ ror_w(tmp, 1, w, mask) ^ c ^ {63'd0, zbit(CZ[sel], (i - m) % 62)});
        end
        rk = '0;
        for (int i = 0; i < m; i++) rk = rk | (256'(k[t-1-i]) << (i * w));
        zi = 256'((ns - 1) % 62);
`ifdef SIMON_KEYPREP_2STEP_EN
        lat = (ns + 1) / 2 + 1;
`else
        lat = ns + 1;
`endif
    endtask

    task automatic check_reset_state(input int sel, input string tag);
        check({tag, "_ctl"}, {key_ready[sel], rkey_valid[sel], busy[sel], zidx[sel]}, 9'b100_000000);
        check({tag, "_rkey"}, get_rkey(sel), '0);
    endtask

    // Present a key and complete the handshake; acc is the cycle the handshake occupied.
    task automatic start_op(input int sel, input logic [255:0] key, input string tag, output int acc);
        int n;
        n = 0;
        while (!key_ready[sel] && n < 10) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_ready"}, key_ready[sel], 1'b1);
        key_in[sel] = key;
        key_valid[sel] = 1'b1;
        acc = cyc;
        @(posedge clk); #1;
        key_valid[sel] = 1'b0;
        check({tag, "_run"}, {key_ready[sel], busy[sel], rkey_valid[sel]}, 3'b010);
    endtask

    task automatic wait_valid(input int sel);
        int n;
        n = 0;
        while (!rkey_valid[sel] && n < 200) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic do_op(input int sel, input logic [255:0] key, input int bp, input string tag);
        logic [255:0] rk_e, zi_e;
        int           lat_e, acc;
        model(sel, key, rk_e, zi_e, lat_e);
        start_op(sel, key, tag, acc);
        wait_valid(sel);
        check({tag, "_lat"}, 256'(cyc - acc), 256'(lat_e));
        check({tag, "_rkey"}, get_rkey(sel), rk_e);
        check({tag, "_zidx"}, 256'(zidx[sel]), zi_e);
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_ctl"}, {rkey_valid[sel], key_ready[sel], busy[sel]}, 3'b100);
            check({tag, "_hold_rkey"}, get_rkey(sel), rk_e);
        end
        rkey_ready[sel] = 1'b1;
        @(posedge clk); #1;
        rkey_ready[sel] = 1'b0;
        check({tag, "_idle_ctl"}, {rkey_valid[sel], key_ready[sel], busy[sel]}, 3'b010);
        check({tag, "_idle_rkey"}, get_rkey(sel), rk_e);
    endtask

    initial begin
        int   acc;
        logic seen;
        for (int i = 0; i < NI; i++) begin
            key_valid[i] = 1'b0;
            rkey_ready[i] = 1'b0;
            key_in[i] = '0;
        end
        #23 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NI; i++) check_reset_state(i, "reset");

        // Simon32/64 vector: words [3]..[0] = 1918 1110 0908 0100.
        do_op(0, 256'h1918_1110_0908_0100, 0, "tv16");
        do_op(0, rand_key(), 10, "bp16");

        // Flush during RUN: abort, no valid result, then a clean run.
        start_op(0, rand_key(), "fl", acc);
        repeat (4) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_ctl", {key_ready[0], rkey_valid[0], busy[0]}, 3'b100);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen = seen | rkey_valid[0];
        end
        check("flush_no_valid", seen, 1'b0);
        do_op(0, rand_key(), 1, "after_flush");

        // Flush wins over a coincident key handshake.
        key_in[2] = rand_key();
        key_valid[2] = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        key_valid[2] = 1'b0;
        flush = 1'b0;
        check("flush_vs_key", {key_ready[2], busy[2]}, 2'b10);

        for (int i = 0; i < 100; i++) do_op(1, rand_key(), $urandom_range(0, 2), "r64");
        for (int i = 0; i < 20; i++) do_op(0, rand_key(), $urandom_range(0, 2), "r16");
        for (int i = 0; i < 20; i++) do_op(2, rand_key(), $urandom_range(0, 2), "r24");

        // Asynchronous reset mid-RUN.
        start_op(1, rand_key(), "rst_run", acc);
        repeat (10) begin @(posedge clk); #1; end
        #3 rst_n = 1'b0;
        #1 check_reset_state(1, "rst_run_async");
        #2 rst_n = 1'b1;
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            seen = seen | rkey_valid[1];
        end
        check("rst_run_no_valid", seen, 1'b0);
        do_op(1, rand_key(), 0, "after_rst_run");

        // Asynchronous reset while DONE.
        start_op(2, rand_key(), "rst_done", acc);
        wait_valid(2);
        check("rst_done_valid", rkey_valid[2], 1'b1);
        #3 rst_n = 1'b0;
        #1 check_reset_state(2, "rst_done_async");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(2, rand_key(), 1, "after_rst_done");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/simon_dec_key_prep.md
Name: simon_dec_key_prep

Overview:
Sequential key pre-expansion engine for Simon decryption. It accepts the master key, runs the forward Simon key schedule T-NKW steps at one step per cycle, and presents the last NKW round keys in reverse order. The decryption datapath can then walk the schedule backward in decrypt mode from that state. It sits between the key register file and the round datapath and generates the c^z constant internally.

Parameters:
WW, 16, word size n; legal values 16, 24, 32, 48, 64
NKW, 4, key words m; legal (WW,NKW) pairs per the Simon parameter table
NSTEP, derived localparam T-NKW, number of forward schedule steps; T from the table (e.g. 32 for 16/4, 72 for 64/4)
ZSEQ, derived localparam, 62-bit constant z0..z4 selected from (WW,NKW) per the Simon parameter table

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  synchronous abort; returns the block to IDLE
key_valid_i  in  1  master key valid
key_ready_o  out  1  block can accept a key (high only in IDLE)
key_i  in  NKW*WW  master key; word [i] = k_i
rkey_valid_o  out  1  decryption start state valid
rkey_ready_i  in  1  consumer accepts the decryption start state
rkey_o  out  NKW*WW  word [i] = k_{T-1-i}; word [0] is the first decryption round key
zidx_o  out  6  z index the decryption schedule uses first: (NSTEP-1) mod 62
busy_o  out  1  high in RUN

Behaviour:
- Reset (async, rst_ni=0): state=IDLE, step_cnt=0, key state=0. Outputs: key_ready_o=1, rkey_valid_o=0, rkey_o=0, zidx_o=0, busy_o=0.
- FSM states are IDLE, RUN and DONE.
- IDLE: key_ready_o=1. On key_valid_i&&key_ready_o, capture ks[i]=key_i[i], set step_cnt=0 and go to RUN.
- RUN: each cycle, ks shifts down. The new ks[NKW-1] = ks[0] ^ t ^ (t>>>1) ^ c ^ z[step_cnt mod 62].
  - c = 2^WW-4. z bit j is bit j of ZSEQ, with bit 0 the leftmost digit as published.
  - NKW=4: t = (ks[3]>>>3) ^ ks[1]. NKW=2/3: t = ks[NKW-1]>>>3. Here >>> is right rotate within WW.
  - step_cnt increments each cycle. When step_cnt==NSTEP-1 the step is applied, then go to DONE.
- Latency: master key accepted at cycle t gives rkey_valid_o=1 at cycle t+NSTEP+1.
- DONE: rkey_valid_o=1. rkey_o[i]=ks[NKW-1-i] and zidx_o=(NSTEP-1) mod 62.
  - rkey_o and zidx_o stay stable while rkey_valid_o&&!rkey_ready_i.
  - On rkey_ready_i, go to IDLE. rkey_valid_o drops next cycle; rkey_o holds its last value.
- No back-to-back key acceptance: key_ready_o=0 in RUN and DONE. key_valid_i is ignored there.
- flush_i in any state: go to IDLE next cycle, step_cnt=0, rkey_valid_o=0. flush_i takes priority over a coincident key or rkey handshake; that handshake does not complete.
- z index wrap: step_cnt mod 62 is implemented as a separate 6-bit counter that wraps 61→0. This applies to NSTEP>62 (WW=64/NKW=4: NSTEP=68).
- Reset asserted mid-RUN: immediate return to IDLE and reset values; no partial output is ever flagged valid.
- Elaboration-time assertions reject illegal (WW,NKW) pairs, using the same legality set as the key schedule.

Optional Feature:
SIMON_KEYPREP_2STEP_EN
- Defined: the RUN state applies two schedule steps per cycle, using z indices j and j+1 (each mod 62).
  - step_cnt advances by 2.
  - If NSTEP is odd, the final RUN cycle applies one step.
  - Latency becomes ceil(NSTEP/2)+1 cycles.
  - rkey_o and zidx_o values are identical to the single-step build.
- Undefined: one step per cycle as above.

Test Plan:
- WW=16,NKW=4, key_i={0x1918,0x1110,0x0908,0x0100} (words [3]..[0]) → after the first RUN cycle ks[3]=0x71C3. rkey_valid_o rises exactly 29 cycles after acceptance. rkey_o matches the golden model's k31..k28, and zidx_o=27.
- WW=64,NKW=4, random keys ×100 → rkey_o matches the golden model (exercises z wrap 61→0, NSTEP=68), and zidx_o=5.
- Backpressure: hold rkey_ready_i=0 for 10 cycles in DONE → rkey_valid_o stays 1, rkey_o is stable, key_ready_o=0. Assert ready → IDLE next cycle.
- flush_i pulsed at step 5 of RUN → next cycle state=IDLE, key_ready_o=1, no rkey_valid_o. A new key then completes correctly.
- rst_ni dropped mid-RUN and during DONE → all outputs return to their reset values asynchronously. The next operation is correct.
- SIMON_KEYPREP_2STEP_EN defined, WW=24,NKW=3 (NSTEP=33) → latency 18 cycles, and rkey_o/zidx_o equal the single-step build.
